gdp_sequencer: RTL and testbench
================================

// Module: gdp_sequencer
// PURPOSE
//  Frame-level scheduler for the Gaussian distance pipeline (gdp). On each new observation vector it walks
//  every senone x component, fetches (k,omega,mean) from stat storage via req/valid handshake, issues one
//  operand set per accepted fetch into gdp, collects per-senone ln_p results and writes them to score storage.
//  Credit flow control guarantees results never overflow the internal score FIFO.
// PARAMETERS
//  N_COMPONENTS  25   components per observation vector / per senone
//  N_SENONES     512  senones scored per frame
//  STAT_AW       14   stat address width, >= clog2(N_SENONES*N_COMPONENTS)
//  SCORE_DEPTH   4    score FIFO depth = senone credits (power of 2, >=2)
// PORTS
//  clk          in   1                 clock, all logic on rising edge
//  reset        in   1                 asynchronous, active-low reset
//  new_vector   in   1                 1-cycle pulse: x valid, start frame
//  x            in   N_COMPONENTS*16   observation vector, component c at [c*16 +: 16]
//  busy         out  1                 frame in progress (state != IDLE)
//  frame_done   out  1                 1-cycle pulse: all N_SENONES scores acked
//  err          out  1                 sticky: gdp result arrived with FIFO full
//  stat_req     out  1                 stat fetch request, held until stat_valid
//  stat_addr    out  STAT_AW           senone*N_COMPONENTS + component
//  stat_valid   in   1                 1-cycle: stat_data valid for current stat_addr
//  stat_data    in   48                {k[47:32], omega[31:16], mean[15:0]}
//  gdp_valid    out  1                 1-cycle issue strobe for gdp_* operands
//  gdp_x, gdp_k, gdp_omega, gdp_mean  out  16 each  registered operands
//  gdp_first    out  1                 issued component is 0 (qualified by gdp_valid)
//  gdp_last     out  1                 issued component is N_COMPONENTS-1
//  gdp_ready    in   1                 1-cycle: gdp_ln_p is a completed senone score, in issue order
//  gdp_ln_p     in   16                senone log-probability
//  score_we     out  1                 write request, held until score_ack
//  score_addr   out  9                 senone index of head FIFO entry
//  score_data   out  16                ln_p of head FIFO entry
//  score_ack    in   1                 write accepted this cycle
// BEHAVIOUR
//  Reset (any time, incl. mid-frame): state IDLE, all outputs 0, indices/FIFO/credits cleared,
//  credits=SCORE_DEPTH. In-flight gdp results after reset are not this block's concern.
//  States: IDLE -> FETCH -> DRAIN -> DONE -> IDLE.
//  IDLE: on new_vector latch x into internal register, comp=0, sen=0, wr_sen=0, clear err, -> FETCH.
//   new_vector outside IDLE is ignored (no restart, x register unchanged).
//  FETCH: stat_req=1, stat_addr=sen*N_COMPONENTS+comp, except stall (stat_req=0) when comp==0 and
//   credits==0. On stat_req&&stat_valid: next cycle gdp_valid=1 with gdp_x=x_reg[comp], stat fields,
//   gdp_first/last; credits-=1 if comp==0; advance comp (wrap to 0, sen+=1 at N_COMPONENTS-1).
//   After issuing comp N_COMPONENTS-1 of senone N_SENONES-1 -> DRAIN. stat_addr advances the cycle after
//   stat_valid, so stat_req may stay high back-to-back: peak throughput 1 component/cycle.
//  stat_addr must not change while stat_req=1 and stat_valid=0.
//  Scores: gdp_ready pushes gdp_ln_p into FIFO. Head drives score_we/score_data, score_addr=wr_sen.
//   On score_we&&score_ack: pop, wr_sen+=1, credits+=1. Push and pop in the same cycle both take effect;
//   credit decrement and increment in the same cycle cancel.
//  gdp_ready while FIFO full (credit violation by gdp): result dropped, err<=1 (sticky until next frame).
//  DRAIN: wait until wr_sen==N_SENONES (all scores acked) -> DONE.
//  DONE: frame_done=1 for exactly one cycle -> IDLE. busy=0 from the cycle after DONE.
//  No arithmetic on data; senone/score counters are 9/10-bit, comp counter clog2(N_COMPONENTS).
// TESTING (bench params N_COMPONENTS=2, N_SENONES=3, SCORE_DEPTH=2; gdp model = fixed 5-cycle latency)
//  1 Single frame, stat_valid 1 cycle after each req, score_ack immediate: x={16'h0002,16'h0001}
//    -> stat_addr seq 0..5, gdp_x 1,2,1,2,1,2, first/last alternate, score_addr 0,1,2, one frame_done.
//  2 score_ack held 0 for 30 cycles: after 2 senones issued stat_req=0 at comp 0 (credits 0);
//    releasing ack resumes senone 2; no err, scores in order.
//  3 stat_valid delayed 3 cycles per req: stat_addr/stat_req stable while waiting, gdp_valid only after
//    each stat_valid, 6 issues total.
//  4 new_vector pulsed mid-frame with different x: ignored, gdp_x keeps original values, single frame_done.
//  5 reset low during FETCH at sen=1: all outputs 0 asynchronously; after release new_vector runs full frame
//    from stat_addr 0.
//  6 gdp model injects extra gdp_ready with FIFO full -> err=1 held; cleared at next new_vector.

Source files
------------

// File: rtl/gdp_sequencer_if.sv
// Handshake bundle between the gdp frame sequencer and its stat store, gdp pipeline and score store.
interface gdp_sequencer_if #(
    parameter int N_COMPONENTS = 25,
    parameter int STAT_AW      = 14
);
    logic                       new_vector;
    logic [N_COMPONENTS*16-1:0] x;
    logic                       busy;
    logic                       frame_done;
    logic                       err;
    logic                       stat_req;
    logic [STAT_AW-1:0]         stat_addr;
    logic                       stat_valid;
    logic [47:0]                stat_data;
    logic                       gdp_valid;
    logic [15:0]                gdp_x;
    logic [15:0]                gdp_k;
    logic [15:0]                gdp_omega;
    logic [15:0]                gdp_mean;
    logic                       gdp_first;
    logic                       gdp_last;
    logic                       gdp_ready;
    logic [15:0]                gdp_ln_p;
    logic                       score_we;
    logic [8:0]                 score_addr;
    logic [15:0]                score_data;
    logic                       score_ack;

    modport master (
        input  new_vector, x, stat_valid, stat_data, gdp_ready, gdp_ln_p, score_ack,
        output busy, frame_done, err, stat_req, stat_addr,
               gdp_valid, gdp_x, gdp_k, gdp_omega, gdp_mean, gdp_first, gdp_last,
               score_we, score_addr, score_data
    );

    modport slave (
        output new_vector, x, stat_valid, stat_data, gdp_ready, gdp_ln_p, score_ack,
        input  busy, frame_done, err, stat_req, stat_addr,
               gdp_valid, gdp_x, gdp_k, gdp_omega, gdp_mean, gdp_first, gdp_last,
               score_we, score_addr, score_data
    );
endinterface

// File: rtl/gdp_sequencer.sv
// Frame scheduler for the Gaussian distance pipeline: fetches stats per senone x component, issues
// operands to gdp and drains per-senone scores through a credit-limited FIFO to score storage.
module gdp_sequencer #(
    parameter int N_COMPONENTS = 25,
    parameter int N_SENONES    = 512,
    parameter int STAT_AW      = 14,
    parameter int SCORE_DEPTH  = 4
) (
    input  logic           clk,
    input  logic           reset,
    gdp_sequencer_if.master bus
);
    localparam int CW  = (N_COMPONENTS > 1) ? $clog2(N_COMPONENTS) : 1;
    localparam int SW  = $clog2(N_SENONES + 1);
    localparam int CRW = $clog2(SCORE_DEPTH + 1);
    localparam int PW  = $clog2(SCORE_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [15:0]        x_q [N_COMPONENTS];
    logic [CW-1:0]      comp_q;
    logic [SW-1:0]      sen_q;
    logic [SW-1:0]      wr_sen_q;
    logic [STAT_AW-1:0] addr_q;
    logic [CRW-1:0]     credits_q;
    logic [CRW-1:0]     cnt_q;
    logic [PW-1:0]      rd_ptr_q, wr_ptr_q;
    logic [15:0]        fifo_q [SCORE_DEPTH];
    logic               err_q;
    logic               gdp_valid_q, gdp_first_q, gdp_last_q;
    logic [15:0]        gdp_x_q, gdp_k_q, gdp_omega_q, gdp_mean_q;

    logic stat_req_c, frame_done_c, issue, start, stall, comp_last, sen_last;
    logic full, push, pop, score_we_c, credit_dec;

    assign comp_last  = (comp_q == CW'(N_COMPONENTS - 1));
    assign sen_last   = (sen_q == SW'(N_SENONES - 1));
    assign stall      = (comp_q == '0) && (credits_q == '0);
    assign start      = (state_q == S_IDLE) && bus.new_vector;
    assign issue      = stat_req_c && bus.stat_valid;
    assign credit_dec = issue && (comp_q == '0);
    assign full       = (cnt_q == CRW'(SCORE_DEPTH));
    assign push       = bus.gdp_ready && !full;
    assign score_we_c = (cnt_q != '0);
    assign pop        = score_we_c && bus.score_ack;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        stat_req_c   = 1'b0;
        frame_done_c = 1'b0;
        case (state_q)
            S_IDLE:  if (bus.new_vector) state_d = S_FETCH;
            S_FETCH: begin
                stat_req_c = !stall;
                if (stat_req_c && bus.stat_valid && comp_last && sen_last) state_d = S_DRAIN;
            end
            S_DRAIN: if (wr_sen_q == SW'(N_SENONES)) state_d = S_DONE;
            S_DONE: begin
                frame_done_c = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Fetch order is linear in sen*N_COMPONENTS+comp, so the address is a plain counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < N_COMPONENTS; i++) x_q[i] <= '0;
            for (int unsigned i = 0; i < SCORE_DEPTH; i++) fifo_q[i] <= '0;
            comp_q      <= '0;
            sen_q       <= '0;
            wr_sen_q    <= '0;
            addr_q      <= '0;
            credits_q   <= CRW'(SCORE_DEPTH);
            cnt_q       <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            err_q       <= 1'b0;
            gdp_valid_q <= 1'b0;
            gdp_first_q <= 1'b0;
            gdp_last_q  <= 1'b0;
            gdp_x_q     <= '0;
            gdp_k_q     <= '0;
            gdp_omega_q <= '0;
            gdp_mean_q  <= '0;
        end else begin
            gdp_valid_q <= 1'b0;
            if (issue) begin
                gdp_valid_q <= 1'b1;
                gdp_x_q     <= x_q[comp_q];
                gdp_k_q     <= bus.stat_data[47:32];
                gdp_omega_q <= bus.stat_data[31:16];
                gdp_mean_q  <= bus.stat_data[15:0];
                gdp_first_q <= (comp_q == '0);
                gdp_last_q  <= comp_last;
                addr_q      <= addr_q + STAT_AW'(1);
                if (comp_last) begin
                    comp_q <= '0;
                    sen_q  <= sen_q + SW'(1);
                end else begin
                    comp_q <= comp_q + CW'(1);
                end
            end
            if (push) begin
                fifo_q[wr_ptr_q] <= bus.gdp_ln_p;
                wr_ptr_q         <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
                wr_sen_q <= wr_sen_q + SW'(1);
            end
            cnt_q     <= cnt_q + CRW'(push) - CRW'(pop);
            credits_q <= credits_q + CRW'(pop) - CRW'(credit_dec);
            if (bus.gdp_ready && full) err_q <= 1'b1;
            if (start) begin
                for (int unsigned i = 0; i < N_COMPONENTS; i++) x_q[i] <= bus.x[i*16 +: 16];
                comp_q   <= '0;
                sen_q    <= '0;
                addr_q   <= '0;
                wr_sen_q <= '0;
                err_q    <= 1'b0;
            end
        end
    end

    assign bus.busy       = (state_q != S_IDLE);
    assign bus.frame_done = frame_done_c;
    assign bus.err        = err_q;
    assign bus.stat_req   = stat_req_c;
    assign bus.stat_addr  = addr_q;
    assign bus.gdp_valid  = gdp_valid_q;
    assign bus.gdp_x      = gdp_x_q;
    assign bus.gdp_k      = gdp_k_q;
    assign bus.gdp_omega  = gdp_omega_q;
    assign bus.gdp_mean   = gdp_mean_q;
    assign bus.gdp_first  = gdp_first_q;
    assign bus.gdp_last   = gdp_last_q;
    assign bus.score_we   = score_we_c;
    assign bus.score_addr = 9'(wr_sen_q);
    assign bus.score_data = fifo_q[rd_ptr_q];
endmodule

// File: tb/tb_gdp_sequencer.sv
// Scoreboard bench for gdp_sequencer: reference model fills expectation queues per frame, monitors pop them.
module tb_gdp_sequencer;
    localparam int NC = 2;
    localparam int NS = 3;
    localparam int SD = 2;
    localparam int AW = 14;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    gdp_sequencer_if #(.N_COMPONENTS(NC), .STAT_AW(AW)) bus ();

    gdp_sequencer #(
        .N_COMPONENTS(NC),
        .N_SENONES(NS),
        .STAT_AW(AW),
        .SCORE_DEPTH(SD)
    ) dut (
        .clk(clk),
        .reset(rst_n),
        .bus(bus)
    );

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] k;
        logic [15:0] om;
        logic [15:0] mn;
        logic        first;
        logic        last;
    } iss_t;
    typedef struct packed {
        logic [8:0]  addr;
        logic [15:0] d;
    } scr_t;
    typedef struct {
        int          due;
        logic [15:0] v;
    } pend_t;

    iss_t  exp_iss[$];
    scr_t  exp_scr[$];
    int    exp_addr[$];
    pend_t pipe[$];
    logic [47:0] stat_mem [NC*NS];

    int n_cmp = 0, n_fail = 0;
    int cyc = 0, done_cnt = 0, fs_done = 0, n_iss = 0, g_ready_cnt = 0, last_acc_cyc = -10;
    int stat_dly = 0, ack_pct = 100;
    bit stat_rand = 1'b0, ack_en = 1'b1, inj = 1'b0;

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_extra(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: DUT produced an output with no expected entry (t=%0t)", name, $time);
    endtask

    // Stat store: responds after a programmable wait, single-cycle valid pulse.
    initial begin : stat_resp
        int wait_c, dly, a;
        logic prev_wait;
        logic [AW-1:0] prev_addr;
        wait_c = 0; dly = 0; prev_wait = 1'b0; prev_addr = '0;
        bus.stat_valid = 1'b0;
        bus.stat_data  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus.stat_valid = 1'b0;
                wait_c = 0;
                prev_wait = 1'b0;
                continue;
            end
            if (prev_wait && bus.stat_req) chk("stat_addr_stable", 128'(bus.stat_addr), 128'(prev_addr));
            if (bus.stat_valid) begin
                bus.stat_valid = 1'b0;
            end else if (bus.stat_req) begin
                if (wait_c == 0) dly = stat_rand ? int'($urandom_range(3, 0)) : stat_dly;
                if (wait_c >= dly) begin
                    if (exp_addr.size() == 0) fail_extra("stat_addr_seq");
                    else chk("stat_addr_seq", 128'(bus.stat_addr), 128'(exp_addr.pop_front()));
                    a = int'(bus.stat_addr);
                    bus.stat_data  = (a < NC*NS) ? stat_mem[a] : '0;
                    bus.stat_valid = 1'b1;
                    last_acc_cyc   = cyc;
                    wait_c = 0;
                end else begin
                    wait_c++;
                end
            end
            prev_wait = bus.stat_req && !bus.stat_valid;
            prev_addr = bus.stat_addr;
        end
    end

    initial begin : score_acker
        bus.score_ack = 1'b0;
        forever begin
            @(negedge clk);
            bus.score_ack = rst_n && ack_en && bus.score_we &&
                            (int'($urandom_range(100, 1)) <= ack_pct);
        end
    end

    // gdp stand-in: XOR-folds the operands of each senone, answers 5 cycles after the last issue.
    initial begin : gdp_model
        logic [15:0] acc;
        pend_t p;
        acc = '0;
        bus.gdp_ready = 1'b0;
        bus.gdp_ln_p  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pipe.delete();
                bus.gdp_ready = 1'b0;
                continue;
            end
            bus.gdp_ready = 1'b0;
            if (pipe.size() > 0 && pipe[0].due <= cyc) begin
                p = pipe.pop_front();
                bus.gdp_ready = 1'b1;
                bus.gdp_ln_p  = p.v;
                g_ready_cnt++;
            end else if (inj) begin
                bus.gdp_ready = 1'b1;
                bus.gdp_ln_p  = 16'hBAD0;
                inj = 1'b0;
            end
            if (bus.gdp_valid) begin
                acc = (bus.gdp_first ? 16'h0 : acc) ^ bus.gdp_x ^ bus.gdp_k ^ bus.gdp_omega ^ bus.gdp_mean;
                if (bus.gdp_last) pipe.push_back('{cyc + 4, acc});
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && bus.gdp_valid) begin
                n_iss++;
                chk("gdp_after_stat", 128'(cyc - last_acc_cyc), 128'(1));
                if (exp_iss.size() == 0) fail_extra("gdp_issue");
                else chk("gdp_issue", 128'({bus.gdp_x, bus.gdp_k, bus.gdp_omega, bus.gdp_mean,
                                           bus.gdp_first, bus.gdp_last}), 128'(exp_iss.pop_front()));
            end
            if (rst_n && bus.score_we && bus.score_ack) begin
                if (exp_scr.size() == 0) fail_extra("score");
                else chk("score", 128'({bus.score_addr, bus.score_data}), 128'(exp_scr.pop_front()));
            end
            if (rst_n && bus.frame_done) done_cnt++;
        end
    end

    // Reference model: expected fetch order, operands and per-senone scores for one frame.
    task automatic start_frame(input logic [31:0] xv);
        logic [15:0] v, xc;
        int a;
        for (int s = 0; s < NS; s++) begin
            v = '0;
            for (int c = 0; c < NC; c++) begin
                a = s*NC + c;
                stat_mem[a] = {16'($urandom), 16'($urandom), 16'($urandom)};
                xc = xv[c*16 +: 16];
                exp_addr.push_back(a);
                exp_iss.push_back('{xc, stat_mem[a][47:32], stat_mem[a][31:16], stat_mem[a][15:0],
                                    c == 0, c == NC-1});
                v = v ^ xc ^ stat_mem[a][47:32] ^ stat_mem[a][31:16] ^ stat_mem[a][15:0];
            end
            exp_scr.push_back('{9'(s), v});
        end
        fs_done = done_cnt;
        g_ready_cnt = 0;
        n_iss = 0;
        bus.x = xv;
        bus.new_vector = 1'b1;
        @(negedge clk);
        bus.new_vector = 1'b0;
    endtask

    task automatic end_frame(input logic exp_err);
        int n;
        n = 0;
        while (done_cnt == fs_done && n < 3000) begin
            @(negedge clk);
            #2;
            n++;
        end
        repeat (4) @(negedge clk);
        #2;
        chk("frame_done_count", 128'(done_cnt - fs_done), 128'(1));
        chk("busy_after_frame", 128'(bus.busy), 128'(0));
        chk("err_after_frame", 128'(bus.err), 128'(exp_err));
        chk("issues_left", 128'(exp_iss.size()), 128'(0));
        chk("scores_left", 128'(exp_scr.size()), 128'(0));
        chk("addrs_left", 128'(exp_addr.size()), 128'(0));
    endtask

    task automatic check_zero(input string p);
        chk({p, "_busy"}, 128'(bus.busy), 128'(0));
        chk({p, "_frame_done"}, 128'(bus.frame_done), 128'(0));
        chk({p, "_err"}, 128'(bus.err), 128'(0));
        chk({p, "_stat_req"}, 128'(bus.stat_req), 128'(0));
        chk({p, "_stat_addr"}, 128'(bus.stat_addr), 128'(0));
        chk({p, "_gdp_valid"}, 128'(bus.gdp_valid), 128'(0));
        chk({p, "_gdp_ops"}, 128'({bus.gdp_x, bus.gdp_k, bus.gdp_omega, bus.gdp_mean,
                                   bus.gdp_first, bus.gdp_last}), 128'(0));
        chk({p, "_score_we"}, 128'(bus.score_we), 128'(0));
        chk({p, "_score_addr"}, 128'(bus.score_addr), 128'(0));
        chk({p, "_score_data"}, 128'(bus.score_data), 128'(0));
    endtask

    initial begin : main
        int n;
        logic [31:0] xv;
        bus.new_vector = 1'b0;
        bus.x = '0;
        repeat (3) @(negedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: back-to-back stats, immediate ack
        start_frame(32'h0002_0001);
        end_frame(1'b0);

        // 2: ack withheld -> credit stall at component 0 of senone 2
        ack_en = 1'b0;
        start_frame({16'($urandom), 16'($urandom)});
        repeat (30) @(negedge clk);
        #2;
        chk("stall_stat_req", 128'(bus.stat_req), 128'(0));
        chk("stall_issued", 128'(n_iss), 128'(2*NC));
        chk("stall_busy", 128'(bus.busy), 128'(1));
        ack_en = 1'b1;
        end_frame(1'b0);

        // 3: slow stat store
        stat_dly = 3;
        start_frame({16'($urandom), 16'($urandom)});
        end_frame(1'b0);
        chk("slow_issue_count", 128'(n_iss), 128'(NC*NS));
        stat_dly = 0;

        // 4: new_vector mid-frame is ignored
        xv = {16'($urandom), 16'($urandom)};
        start_frame(xv);
        repeat (5) @(negedge clk);
        bus.x = ~xv;
        bus.new_vector = 1'b1;
        @(negedge clk);
        bus.new_vector = 1'b0;
        end_frame(1'b0);

        // 5: asynchronous reset during senone 1
        start_frame({16'($urandom), 16'($urandom)});
        n = 0;
        while (n_iss < NC && n < 200) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("rst_at_sen1", 128'(n_iss), 128'(NC));
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        repeat (3) @(negedge clk);
        exp_iss.delete();
        exp_scr.delete();
        exp_addr.delete();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        start_frame(32'h0002_0001);
        end_frame(1'b0);

        // 6: extra gdp result while FIFO full -> sticky err, cleared by next frame
        ack_en = 1'b0;
        start_frame({16'($urandom), 16'($urandom)});
        n = 0;
        while (g_ready_cnt < SD && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("inj_fifo_fill", 128'(g_ready_cnt), 128'(SD));
        repeat (2) @(negedge clk);
        inj = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk("err_set", 128'(bus.err), 128'(1));
        chk("err_stall_req", 128'(bus.stat_req), 128'(0));
        ack_en = 1'b1;
        end_frame(1'b1);
        start_frame({16'($urandom), 16'($urandom)});
        repeat (2) @(negedge clk);
        #2;
        chk("err_cleared", 128'(bus.err), 128'(0));
        end_frame(1'b0);

        // randomized stat latency and ack back-pressure
        stat_rand = 1'b1;
        for (int f = 0; f < 4; f++) begin
            ack_pct = int'($urandom_range(100, 30));
            start_frame({16'($urandom), 16'($urandom)});
            end_frame(1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
